// File: rtl/regfile_writeback.sv
// Register-bank write side: in-order write buffer that retires one entry per cycle into a 32x32 bank (x0 hardwired to 0).
// Optional `WB_BYPASS_EN: a write arriving to an empty buffer with drain_en=1 goes straight into the bank.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic [4:0]             wb_rd,
  input  logic [31:0]            wb_data,
  input  logic                   drain_en,
  output logic [31:0]            register_bank [32],
  output logic [31:0]            rd_pending,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    ent_rd_q  [DEPTH];
  logic [4:0]    ent_rd_d  [DEPTH];
  logic [31:0]   ent_dat_q [DEPTH];
  logic [31:0]   ent_dat_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   bank_q [32];
  logic [31:0]   bank_d [32];

  logic accept, pop, push, bypass;
  logic [PW-1:0] idx;

  assign wb_ready = (cnt_q != CW'(DEPTH));
  assign accept   = wb_valid && wb_ready;
  assign pop      = drain_en && (cnt_q != '0);

`ifdef WB_BYPASS_EN
  assign bypass = accept && (cnt_q == '0) && drain_en && (wb_rd != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // x0 writes are accepted but never occupy an entry
  assign push = accept && (wb_rd != 5'd0) && !bypass;

  always_comb begin
    ent_rd_d  = ent_rd_q;
    ent_dat_d = ent_dat_q;
    bank_d    = bank_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (pop) begin
      bank_d[ent_rd_q[head_q]] = ent_dat_q[head_q];
      head_d = head_q + PW'(1);
    end
    if (bypass) begin
      bank_d[wb_rd] = wb_data;
    end
    if (push) begin
      ent_rd_d[tail_q]  = wb_rd;
      ent_dat_d[tail_q] = wb_data;
      tail_d = tail_q + PW'(1);
    end
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    bank_d[0] = '0;
  end

  always_comb begin
    rd_pending = '0;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < cnt_q) begin
        rd_pending[ent_rd_q[idx]] = 1'b1;
      end
    end
    rd_pending[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd_q[i]  <= '0;
        ent_dat_q[i] <= '0;
      end
      for (int i = 0; i < 32; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      ent_rd_q  <= ent_rd_d;
      ent_dat_q <= ent_dat_d;
      bank_q    <= bank_d;
    end
  end

  assign register_bank = bank_q;
  assign count         = cnt_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: queue-based reference model checked every cycle, plus directed literal checks.
module tb_regfile_writeback;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        drain_en = 1'b0;
  logic [31:0] register_bank [32];
  logic [31:0] rd_pending;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         mq[$];
  logic [31:0] mbank [32];

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .drain_en(drain_en),
    .register_bank(register_bank), .rd_pending(rd_pending), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) p[mq[i].rd] = 1'b1;
    return p;
  endfunction

  // Reference model: pop the oldest entry, then append the new one (or bypass).
  always @(posedge clk or negedge rst) begin
    int  sz;
    bit  byp;
    wr_t e;
    if (!rst) begin
      mq.delete();
      for (int i = 0; i < 32; i++) mbank[i] = '0;
    end else begin
      sz = mq.size();
      byp = 1'b0;
`ifdef WB_BYPASS_EN
      byp = (sz == 0) && drain_en;
`endif
      if (drain_en && sz > 0) begin
        e = mq.pop_front();
        mbank[e.rd] = e.data;
      end
      if (wb_valid && sz < DEPTH && wb_rd != 5'd0) begin
        if (byp) begin
          mbank[wb_rd] = wb_data;
        end else begin
          e.rd = wb_rd;
          e.data = wb_data;
          mq.push_back(e);
        end
      end
    end
  end

  initial for (int i = 0; i < 32; i++) mbank[i] = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 32; i++) begin
        if (register_bank[i] !== mbank[i]) chk($sformatf("model_bank[%0d]", i), register_bank[i], mbank[i]);
      end
      chk("model_bank", 32'(register_bank[0] === mbank[0]), 32'd1);
      chk("model_pending", rd_pending, model_pending());
      chk("model_count", 32'(count), 32'(mq.size()));
      chk("model_ready", 32'(wb_ready), 32'(mq.size() < DEPTH));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rdy;
    // reset state
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(wb_ready), 32'd1);
    chk("rst_pending", rd_pending, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    // 1: single write latency
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h12345678; drain_en = 1'b1;
    tick();
    wb_valid = 1'b0;
`ifdef WB_BYPASS_EN
    chk("t1_bank_e", register_bank[5], 32'h12345678);
    chk("t1_pend_e", rd_pending, 32'd0);
    chk("t1_count_e", 32'(count), 32'd0);
`else
    chk("t1_bank_e", register_bank[5], 32'd0);
    chk("t1_pend_e", rd_pending, 32'h20);
    chk("t1_count_e", 32'(count), 32'd1);
`endif
    tick();
    chk("t1_bank_e1", register_bank[5], 32'h12345678);
    chk("t1_pend_e1", rd_pending, 32'd0);

    // 2: x0 write dropped
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    tick();
    wb_valid = 1'b0;
    chk("t2_bank0", register_bank[0], 32'd0);
    chk("t2_count", 32'(count), 32'd0);
    chk("t2_pend", rd_pending, 32'd0);
    tick();
    chk("t2_bank0_b", register_bank[0], 32'd0);

    // 3: full and backpressure
    drain_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      wb_valid = 1'b1; wb_rd = 5'(i); wb_data = 32'hA0 + 32'(i);
      tick();
    end
    chk("t3_count", 32'(count), 32'd4);
    chk("t3_ready", 32'(wb_ready), 32'd0);
    chk("t3_pend", rd_pending, 32'h1E);
    drain_en = 1'b1;
    rdy = wb_ready;
    tick();
    if (rdy) wb_valid = 1'b0;
    chk("t3_ready_during_pop", 32'(rdy), 32'd0);
    chk("t3_first_retire", register_bank[1], 32'hA1);
    chk("t3_order", register_bank[2], 32'd0);
    for (int j = 0; j < 8; j++) begin
      rdy = wb_ready;
      tick();
      if (rdy) wb_valid = 1'b0;
    end
    for (int i = 1; i <= 5; i++) chk($sformatf("t3_bank%0d", i), register_bank[i], 32'hA0 + 32'(i));
    chk("t3_count_end", 32'(count), 32'd0);

    // 4: same rd ordering
    drain_en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'(i);
      tick();
    end
    wb_valid = 1'b0;
    drain_en = 1'b1;
    chk("t4_pend0", rd_pending, 32'h80);
    tick();
    chk("t4_bank_1", register_bank[7], 32'd1);
    chk("t4_pend_1", rd_pending, 32'h80);
    tick();
    chk("t4_bank_2", register_bank[7], 32'd2);
    chk("t4_pend_2", rd_pending, 32'h80);
    tick();
    chk("t4_bank_3", register_bank[7], 32'd3);
    chk("t4_pend_3", rd_pending, 32'd0);

    // 5: reset mid-operation
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1; wb_rd = 5'(10 + i); wb_data = 32'hC0 + 32'(i);
      tick();
    end
    wb_valid = 1'b0;
    chk("t5_count_pre", 32'(count), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("t5_count_rst", 32'(count), 32'd0);
    begin
      logic [31:0] orv = '0;
      for (int i = 0; i < 32; i++) orv |= register_bank[i];
      chk("t5_bank_zero", orv, 32'd0);
    end
    chk("t5_pend_rst", rd_pending, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drain_en = 1'b1;
    for (int j = 0; j < 4; j++) tick();
    for (int i = 10; i <= 12; i++) chk($sformatf("t5_bank%0d", i), register_bank[i], 32'd0);

    // 6: random traffic against the model
    for (int n = 0; n < 1000; n++) begin
      wb_valid = 1'($urandom_range(0, 1));
      wb_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wb_data  = $urandom;
      drain_en = ($urandom_range(0, 2) != 0);
      tick();
    end
    wb_valid = 1'b0;
    drain_en = 1'b1;
    for (int j = 0; j < 6; j++) tick();
    chk("t6_drained", 32'(count), 32'd0);
    chk("t6_bank0", register_bank[0], 32'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
